// File: rtl/thermo_frame_loader.sv
// thermo_frame_loader: byte-stream feeder for the 256-bit thermometer stage.
// Accepts a frame of bytes over valid/ready and drives shift_en/shift_data.
// Raises sel_shift once the whole frame sits in the shift register.
// Ports: clk, rst (async high); start, abort; in_data/in_valid/in_ready;
//   shift_en, shift_data, sel_shift, busy, frame_done, byte_cnt,
//   frame_count, fmt_err.
// Optional macro THERMO_LOADER_CHECK_EN enables the thermometer-code check
// on fmt_err; without it fmt_err is tied low.
module thermo_frame_loader #(
    parameter int BYTES_PER_FRAME = 32,
    parameter int CNT_W = $clog2(BYTES_PER_FRAME) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic [7:0]       shift_data,
    output logic             sel_shift,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [7:0]       frame_count,
    output logic             fmt_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic xfer;
    logic last_xfer;
    logic start_ok;

    assign xfer      = in_valid & in_ready & ~abort;
    assign last_xfer = xfer &
        (byte_cnt == CNT_W'(BYTES_PER_FRAME - 1));
    // start only counts where a new frame may begin
    assign start_ok  = start & ((state == IDLE) | (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)          state_nxt = IDLE;
                else if (last_xfer) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state == LOAD) | (state == FLUSH);
        sel_shift = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en    <= 1'b0;
            shift_data  <= 8'd0;
            byte_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            shift_en <= xfer;
            if (xfer) shift_data <= in_data;
            if (start_ok) byte_cnt <= '0;
            else if (xfer) byte_cnt <= byte_cnt + CNT_W'(1);
            // FLUSH always leads to DONE, so this marks DONE entry
            frame_done <= (state == FLUSH);
            if (state == FLUSH) frame_count <= frame_count + 8'd1;
        end
    end

`ifdef THERMO_LOADER_CHECK_EN
    logic seen_one;
    logic err_q;
    logic seen_nxt;
    logic err_nxt;

    // walk the byte MSB first; a 0 after any 1 breaks the code
    always_comb begin
        seen_nxt = seen_one;
        err_nxt  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (in_data[i]) seen_nxt = 1'b1;
            else if (seen_nxt) err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_one <= 1'b0;
            err_q    <= 1'b0;
        end else if (start_ok) begin
            seen_one <= 1'b0;
            err_q    <= 1'b0;
        end else if (xfer) begin
            seen_one <= seen_nxt;
            if (err_nxt) err_q <= 1'b1;
        end
    end

    assign fmt_err = err_q;
`else
    assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_frame_loader.sv
// tb_thermo_frame_loader: directed bench with a frame-level reference model.
// Compares every DUT output every cycle, plus hand-computed literal checks.
module tb_thermo_frame_loader;

    localparam int BPF = 32;
    localparam int CW  = $clog2(BPF) + 1;

    typedef logic [7:0] frame_t [BPF];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic [7:0]    shift_data;
    logic          sel_shift;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    frame_count;
    logic          fmt_err;

    thermo_frame_loader #(.BYTES_PER_FRAME(BPF)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .shift_data(shift_data),
        .sel_shift(sel_shift), .busy(busy), .frame_done(frame_done),
        .byte_cnt(byte_cnt), .frame_count(frame_count), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference model: phase 0 idle, 1 loading, 2 last byte draining, 3 shown
    int   m_ph = 0;
    int   m_cnt = 0;
    int   m_fc = 0;
    bit   m_sh_en = 0;
    logic [7:0] m_sh_data = 8'd0;
    bit   m_fd = 0;
    bit   bits[$];

    int   cyc = 0;
    int   acc_cyc = 0;
    int   fd_cyc = 0;
    int   sh_cnt = 0;
    int   fd_cnt = 0;
    logic fmt_at_fd = 1'b0;

`ifdef THERMO_LOADER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // legal thermometer stream = no 1 immediately followed by 0
    function automatic bit bad_code();
        for (int i = 0; i + 1 < bits.size(); i++)
            if (bits[i] && !bits[i+1]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all();
        chk("in_ready", in_ready, m_ph == 1);
        chk("busy", busy, m_ph == 1 || m_ph == 2);
        chk("sel_shift", sel_shift, m_ph == 3);
        chk("shift_en", shift_en, m_sh_en);
        if (m_sh_en) chk("shift_data", shift_data, m_sh_data);
        chk("frame_done", frame_done, m_fd);
        chk("byte_cnt", byte_cnt, m_cnt);
        chk("frame_count", frame_count, m_fc[7:0]);
        chk("fmt_err", fmt_err, CHK & bad_code());
    endtask

    task automatic tick();
        bit x;
        int nph;
        x = in_valid && (m_ph == 1) && !abort;
        nph = m_ph;
        m_sh_en = x;
        if (x) m_sh_data = in_data;
        m_fd = (m_ph == 2);
        case (m_ph)
            0, 3: if (start) begin
                nph = 1;
                m_cnt = 0;
                bits.delete();
            end
            1: if (abort) nph = 0;
               else if (x) begin
                   for (int b = 7; b >= 0; b--) bits.push_back(in_data[b]);
                   m_cnt++;
                   if (m_cnt == BPF) begin
                       nph = 2;
                       acc_cyc = cyc;
                   end
               end
            2: begin
                nph = 3;
                m_fc = (m_fc + 1) % 256;
            end
            default: nph = 0;
        endcase
        @(posedge clk);
        cyc++;
        m_ph = nph;
        #1;
        if (shift_en) sh_cnt++;
        if (frame_done) begin
            fd_cyc = cyc;
            fd_cnt++;
            fmt_at_fd = fmt_err;
        end
        compare_all();
    endtask

    task automatic drive(input logic st, input logic ab, input logic v,
                         input logic [7:0] d);
        start = st;
        abort = ab;
        in_valid = v;
        in_data = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_ph = 0; m_cnt = 0; m_fc = 0; m_sh_en = 0; m_fd = 0;
        bits.delete();
        chk("rst_zero", {in_ready, shift_en, shift_data, sel_shift, busy,
                         frame_done, 8'(byte_cnt), frame_count, fmt_err}, 0);
        compare_all();
        rst = 1'b0;
        #1;
    endtask

    // feed bytes until the model says the frame is complete, then walk
    // through the drain and display cycles with in_valid still high
    task automatic load(input frame_t fr, input bit gaps);
        int guard = 0;
        sh_cnt = 0;
        while (m_ph == 1 && guard < 2000) begin
            if (gaps && $urandom_range(0, 2) == 0) drive(0, 0, 0, 8'hAA);
            else drive(0, 0, 1, fr[m_cnt]);
            guard++;
        end
        chk("load_reached_flush", m_ph, 2);
        drive(0, 0, 1, 8'h55);
        drive(0, 0, 1, 8'h66);
    endtask

    function automatic frame_t mk(input logic [7:0] mid);
        frame_t f;
        for (int i = 0; i < BPF; i++)
            f[i] = (i < 19) ? 8'h00 : (i == 19) ? mid : 8'hFF;
        return f;
    endfunction

    initial begin
        frame_t fa;
        frame_t ff;
        int guard;
        fa = mk(8'h0F);
        for (int i = 0; i < BPF; i++) ff[i] = 8'hFF;

        #2;
        do_reset();

        // reset in the middle of a frame
        drive(1, 0, 0, 8'h00);
        drive(0, 0, 1, 8'h12);
        drive(0, 0, 1, 8'h34);
        do_reset();

        // start, then full-rate frame
        drive(1, 0, 0, 8'h00);
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
        load(fa, 0);
        chk("sh_cnt_frame1", sh_cnt, 32);
        chk("fd_latency", fd_cyc - acc_cyc, 2);
        chk("frame_count_1", frame_count, 8'd1);
        chk("fmt_frame1", fmt_at_fd, 0);
        drive(0, 0, 1, 8'h77);

        // restart from DONE, frame with gaps
        drive(1, 0, 0, 8'h00);
        chk("sel_drop_on_start", sel_shift, 0);
        load(fa, 1);
        chk("sh_cnt_gaps", sh_cnt, 32);
        chk("frame_count_2", frame_count, 8'd2);

        // abort after 10 bytes, start inside LOAD ignored
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) drive(i == 4, 0, 1, 8'(i + 1));
        guard = fd_cnt;
        drive(0, 1, 1, 8'hEE);
        chk("abort_idle_ready", in_ready, 0);
        drive(0, 0, 1, 8'hEF);
        chk("abort_byte_cnt", byte_cnt, 10);
        chk("abort_sel", sel_shift, 0);
        chk("abort_no_fd", fd_cnt, guard);

        // format check frames
        drive(1, 0, 0, 8'h00);
        load(mk(8'hF0), 0);
        chk("fmt_f0", fmt_at_fd, CHK);
        drive(1, 0, 0, 8'h00);
        load(ff, 0);
        chk("fmt_ff", fmt_at_fd, 0);

        // run frames until the 8-bit count wraps
        guard = 0;
        while (m_fc != 0 && guard < 300) begin
            drive(1, 0, 0, 8'h00);
            load(ff, 0);
            guard++;
        end
        chk("frame_count_wrap", frame_count, 8'd0);
        chk("frames_total", fd_cnt, 256);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/thermo_frame_loader.md
Name: thermo_frame_loader

Overview:
- Upstream feeder for the 256-bit thermometer output stage.
- Accepts a frame of bytes over a valid/ready stream and drives the stage's byte-wide shift port (shift enable plus 8-bit data).
- Once a full frame has landed in the shift register, raises the select line that switches the output register from the internal encoder to the shifted pattern.
- Optionally checks that the loaded frame is a legal thermometer code.

Parameters:
- BYTES_PER_FRAME, 32, bytes per frame; 32 x 8 = 256-bit shift register.
- CNT_W, $clog2(BYTES_PER_FRAME)+1, width of the byte counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new frame (level sampled each cycle)
- abort  input  1  cancel the frame in progress
- in_data  input  8  stream byte; first byte lands in shift bits [255:248]
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- shift_en  output  1  registered one-cycle shift strobe to the shift register
- shift_data  output  8  registered byte accompanying shift_en
- sel_shift  output  1  select for the output register: 1 = shifted pattern, 0 = encoder
- busy  output  1  high in LOAD or FLUSH
- frame_done  output  1  one-cycle pulse when sel_shift rises
- byte_cnt  output  CNT_W  bytes accepted in the current frame
- frame_count  output  8  completed frames, wraps 255 -> 0
- fmt_err  output  1  frame is not a valid thermometer code (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including frame_count, byte_cnt and fmt_err.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: in_ready=0, in_valid ignored. start=1 -> LOAD; byte_cnt cleared, sel_shift=0.
- LOAD:
  - in_ready=1 (combinational from state).
  - Transfer = in_valid & in_ready & ~abort.
  - A transfer in cycle T gives shift_en=1 and shift_data=in_data in T+1. byte_cnt increments at the T edge.
  - start is ignored in LOAD.
  - abort=1 -> IDLE next cycle. A byte presented in the same cycle is dropped (no shift_en). byte_cnt keeps its value until the next start. No frame_done. sel_shift stays 0.
  - The transfer that makes byte_cnt == BYTES_PER_FRAME -> FLUSH.
- FLUSH (1 cycle):
  - in_ready=0.
  - The last shift_en is on the wire this cycle.
  - abort is ignored.
  - -> DONE.
- DONE:
  - sel_shift=1 and frame_done=1 on entry cycle only.
  - frame_count increments on entry, 8-bit wrap.
  - sel_shift holds 1 while in DONE.
  - start=1 -> LOAD; sel_shift drops to 0 the next cycle, so partial frames are never presented.
  - abort in DONE is ignored.
- Timing for the last byte accepted at T: shift_en at T+1, sel_shift/frame_done at T+2. The shift register is therefore fully updated before it is selected.
- shift_en never asserts in two consecutive cycles unless transfers occurred in consecutive cycles. Back-to-back transfers at full rate are supported.
- Reset mid-frame: immediate return to IDLE, all outputs 0, no shift_en glitch.

Optional Feature:
- Macro: THERMO_LOADER_CHECK_EN
- With the macro defined:
  - Bits are scanned in stream order: per byte, bit 7 down to bit 0, in frame order.
  - A seen_one flag sets on the first 1.
  - Any 0 after seen_one sets fmt_err (sticky).
  - seen_one and fmt_err clear on start from IDLE or DONE.
  - fmt_err updates with the transfer edge, so it is final when frame_done pulses.
  - All-0 and all-1 frames are legal.
- Without the macro: fmt_err tied to 0 and no check logic is synthesised.

Test Plan:
- Reset and start:
  - Assert rst mid-stream -> all outputs 0 immediately.
  - Release, pulse start -> in_ready=1 next cycle, busy=1.
- Full frame at full rate:
  - Stimulus: 19x 0x00, 0x0F, 12x 0xFF with in_valid held.
  - 32 shift_en pulses carry the exact bytes, each one cycle after acceptance.
  - sel_shift and frame_done rise 2 cycles after the 32nd acceptance; frame_count=1; fmt_err=0.
- Backpressure and gaps:
  - Drop in_valid randomly; frame still completes after exactly 32 transfers.
  - in_valid during FLUSH/DONE/IDLE produces no shift_en.
- Abort:
  - After 10 bytes, assert abort together with in_valid -> that byte is not shifted; IDLE; sel_shift=0; no frame_done; byte_cnt=10.
  - start during LOAD is ignored.
- Restart from DONE:
  - start in DONE -> sel_shift=0 next cycle.
  - Second frame completes with frame_count=2.
  - 256 frames wrap frame_count to 0.
- Format check (macro on):
  - Same frame with 0xF0 in place of 0x0F -> fmt_err=1 at frame_done.
  - Next frame of 32x 0xFF -> fmt_err=0.
  - Macro off -> fmt_err always 0.
